systolic_ctrl: RTL

Sequencer for the N×N weight-stationary float32 systolic array. Per job it loads one weight row per cycle from the weight buffer, then streams activation vectors from the activation buffer. Each array row gets its lanes with a per-row skew, and the controller deskews the bottom-row partial sums into whole result vectors. It sits between the two scratchpad buffers and the array, and owns the array's `compute` and per-row `weight_en` strobes.

---
 rtl/systolic_pkg.sv | 27 ++
 rtl/lane_delay.sv | 33 +++
 rtl/systolic_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array controller: FSM states, float32 width/zero
// constant and a lane extraction helper for packed N*32 buses.
package systolic_pkg;

    localparam int unsigned FP_W      = 32;
    localparam logic [FP_W-1:0] FP_ZERO = '0;

    // Widest bus lane_slice accepts; callers zero-extend their bus to this width.
    localparam int unsigned LANES_MAX = 64;
    localparam int unsigned BUS_MAX   = LANES_MAX * FP_W;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StStream,
        StDrain,
        StDone
    } ctrl_state_e;

    function automatic logic [FP_W-1:0] lane_slice(input logic [BUS_MAX-1:0] bus,
                                                   input int unsigned        lane);
        logic [BUS_MAX-1:0] sh;
        sh = bus >> (lane * FP_W);
        return sh[FP_W-1:0];
    endfunction

endpackage

// File: rtl/lane_delay.sv
// Fixed-depth register delay line for one lane; Depth = 0 is a plain passthrough.
module lane_delay #(
    parameter int unsigned Depth = 1,
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    if (Depth == 0) begin : g_pass
        assign q = d;
    end else begin : g_regs
        logic [Width-1:0] stage_q [Depth];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < Depth; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                stage_q[0] <= d;
                for (int k = 1; k < Depth; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end

        assign q = stage_q[Depth-1];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN weight-stationary float32 systolic array: weight load, skewed stream,
// deskewed results. Define SYSTOLIC_CTRL_WKEEP_EN to add cfg_keep_w (skip the weight load).
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned  N       = 4,
    parameter int unsigned  VEC_MAX = 256,
    localparam int unsigned VW      = $clog2(VEC_MAX + 1),
    localparam int unsigned AW      = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef SYSTOLIC_CTRL_WKEEP_EN
    input  logic              cfg_keep_w,
`endif
    input  logic [VW-1:0]     cfg_num_vec,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [AW-1:0]     w_rd_addr,
    input  logic [N*FP_W-1:0] w_rd_data,
    output logic [N*FP_W-1:0] arr_weight_in,
    output logic [N-1:0]      arr_weight_en,
    output logic              act_rd_en,
    output logic [VW-1:0]     act_rd_addr,
    input  logic [N*FP_W-1:0] act_rd_data,
    output logic [N*FP_W-1:0] arr_west,
    output logic              arr_compute,
    input  logic [N*FP_W-1:0] arr_south,
    output logic              out_valid,
    output logic [N*FP_W-1:0] out_data,
    output logic [VW-1:0]     out_idx
);

    // One counter serves weight rows (0..N), vectors (0..num_vec-1) and drain cycles (0..2N-1).
    localparam int unsigned CW = (VW > AW + 2) ? VW : AW + 2;

    ctrl_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   num_vec_q, num_vec_d, num_vec_clamp;
    logic [VW-1:0]   idx_q, idx_d;
    logic [N-1:0]    wen_q, wen_d;
    logic            act_vld_q;
    logic [2*N-1:0]  vld_sr_q;
    logic            keep_req;

`ifdef SYSTOLIC_CTRL_WKEEP_EN
    assign keep_req = cfg_keep_w;
`else
    assign keep_req = 1'b0;
`endif

    assign num_vec_clamp = (cfg_num_vec > VW'(VEC_MAX)) ? VW'(VEC_MAX) : cfg_num_vec;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        num_vec_d   = num_vec_q;
        busy        = (state_q != StIdle);
        done        = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        act_rd_en   = 1'b0;
        act_rd_addr = '0;
        arr_compute = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_vec_d = num_vec_clamp;
                    cnt_d     = '0;
                    if (keep_req) begin
                        state_d = (num_vec_clamp == '0) ? StDone : StStream;
                    end else begin
                        state_d = StLoadW;
                    end
                end
            end
            StLoadW: begin
                if (cnt_q < CW'(N)) begin
                    w_rd_en   = 1'b1;
                    w_rd_addr = cnt_q[AW-1:0];
                end
                // Extra cycle lets the last row's enable fire before streaming begins.
                if (cnt_q == CW'(N)) begin
                    cnt_d   = '0;
                    state_d = (num_vec_q == '0) ? StDone : StStream;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStream: begin
                act_rd_en   = 1'b1;
                act_rd_addr = cnt_q[VW-1:0];
                arr_compute = 1'b1;
                if (cnt_q + CW'(1) == CW'(num_vec_q)) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDrain: begin
                arr_compute = 1'b1;
                if (cnt_q == CW'(2 * N - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wen_d = '0;
        if (w_rd_en) begin
            wen_d = N'(1) << w_rd_addr;
        end
        idx_d = idx_q;
        if (state_q == StDone) begin
            idx_d = '0;
        end else if (out_valid) begin
            idx_d = idx_q + VW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            num_vec_q <= '0;
            idx_q     <= '0;
            wen_q     <= '0;
            act_vld_q <= 1'b0;
            vld_sr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_vec_q <= num_vec_d;
            idx_q     <= idx_d;
            wen_q     <= wen_d;
            act_vld_q <= act_rd_en;
            vld_sr_q  <= {vld_sr_q[2*N-2:0], act_rd_en};
        end
    end

    assign arr_weight_en = wen_q;
    assign arr_weight_in = (|wen_q) ? w_rd_data : '0;
    assign out_valid     = vld_sr_q[2*N-1];
    assign out_idx       = idx_q;

    logic [FP_W-1:0] skew_in   [N];
    logic [FP_W-1:0] skew_out  [N];
    logic [FP_W-1:0] dsk_in    [N];
    logic [FP_W-1:0] dsk_out   [N];

    for (genvar i = 0; i < N; i++) begin : g_lane
        // Bubbles enter the skew lines as +0.0 so idle PEs accumulate nothing.
        assign skew_in[i] = act_vld_q ? lane_slice(BUS_MAX'(act_rd_data), i) : FP_ZERO;
        assign dsk_in[i]  = lane_slice(BUS_MAX'(arr_south), i);

        lane_delay #(
            .Depth (i),
            .Width (FP_W)
        ) u_skew (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (skew_in[i]),
            .q     (skew_out[i])
        );

        lane_delay #(
            .Depth (N - 1 - i),
            .Width (FP_W)
        ) u_deskew (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (dsk_in[i]),
            .q     (dsk_out[i])
        );

        assign arr_west[i*FP_W +: FP_W] = skew_out[i];
        // Column N-1 is a passthrough of the array; gate so stale array state never leaks out.
        assign out_data[i*FP_W +: FP_W] = out_valid ? dsk_out[i] : FP_ZERO;
    end

endmodule
